// File: rtl/alu_seq_muldiv_if.sv
// Request/response handshake bundle for alu_seq_muldiv: operand channel in, registered result channel out.
interface alu_seq_muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            div_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, div_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, div_zero
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// RV32I/M execution unit: single-cycle base ops, iterative shift-add multiply and restoring divide.
// Define FAST_MUL_EN to use a combinational multiplier (ops 16-19 complete in one cycle).
module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst_n,
  alu_seq_muldiv_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_next;

  logic [SHW-1:0]    cnt;
  logic [XLEN-1:0]   hi, lo, md, result_q;
  logic [2:0]        kind;
  logic              neg_q, neg_r, dz, dz_q;

  logic              accept, op_mul, op_div, op_iter;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, base_res, final_res;
  logic [SHW-1:0]    sh;

  logic [XLEN:0]     mul_sum, div_sh, div_tr;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  logic [XLEN-1:0]   div_q, div_r;

  assign sh     = bus.b[SHW-1:0];
  assign accept = bus.in_valid && (state == IDLE);
  assign op_mul = (bus.op[4:2] == 3'b100);
  assign op_div = (bus.op[4:2] == 3'b101);
`ifdef FAST_MUL_EN
  assign op_iter = op_div;
`else
  assign op_iter = op_mul || op_div;
`endif

  // MULH/MULHSU take a as signed, only MULH takes b as signed; DIV/REM are signed, DIVU/REMU not.
  assign a_signed = op_mul ? (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10) : !bus.op[0];
  assign b_signed = op_mul ? (bus.op[1:0] == 2'b01) : !bus.op[0];
  assign a_neg    = a_signed && bus.a[XLEN-1];
  assign b_neg    = b_signed && bus.b[XLEN-1];
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;

`ifdef FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fprod;
  logic [2*XLEN-1:0]        prod;
  assign fa    = {a_signed & bus.a[XLEN-1], bus.a};
  assign fb    = {b_signed & bus.b[XLEN-1], bus.b};
  assign fprod = fa * fb;
  assign prod  = fprod[2*XLEN-1:0];
`endif

  always_comb begin
    base_res = '0;
    case (bus.op)
      5'd0: base_res = bus.a + bus.b;
      5'd1: base_res = bus.a - bus.b;
      5'd2: base_res = bus.a << sh;
      5'd3: base_res[0] = $signed(bus.a) < $signed(bus.b);
      5'd4: base_res[0] = bus.a < bus.b;
      5'd5: base_res = bus.a ^ bus.b;
      5'd6: base_res = bus.a >> sh;
      5'd7: base_res = $unsigned($signed(bus.a) >>> sh);
      5'd8: base_res = bus.a | bus.b;
      5'd9: base_res = bus.a & bus.b;
`ifdef FAST_MUL_EN
      5'd16, 5'd17, 5'd18, 5'd19:
        base_res = (bus.op == 5'd16) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`endif
      default: ;
    endcase
  end

  // {hi,lo} is shared: product accumulator for multiply, remainder/quotient pair for divide.
  assign mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? md : '0)};
  assign mul_next = {mul_sum, lo[XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_tr   = div_sh - {1'b0, md};
  assign div_ok   = !div_tr[XLEN];
  assign div_q    = {lo[XLEN-2:0], div_ok};
  assign div_r    = div_ok ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0];

  always_comb begin
    final_res = '0;
    if (!kind[2])
      final_res = (kind[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    else if (!kind[1])
      final_res = dz ? '1 : (neg_q ? -div_q : div_q);
    else
      final_res = neg_r ? -div_r : div_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = op_iter ? EXEC : DONE;
      EXEC:    if (cnt == LAST) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      md       <= '0;
      kind     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      if (op_iter) begin
        hi    <= '0;
        lo    <= a_mag;
        md    <= b_mag;
        kind  <= bus.op[2:0];
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz    <= op_div && (bus.b == '0);
      end else begin
        result_q <= base_res;
        dz_q     <= 1'b0;
      end
    end else if (state == EXEC) begin
      cnt <= cnt + 1'b1;
      hi  <= kind[2] ? div_r : mul_next[2*XLEN-1:XLEN];
      lo  <= kind[2] ? div_q : mul_next[XLEN-1:0];
      if (cnt == LAST) begin
        result_q <= final_res;
        dz_q     <= dz;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.div_zero  = dz_q;
endmodule
